// File: rtl/bs_tap_controller_pkg.sv
// Shared types for the boundary-scan TAP controller: state encoding, data-register
// select and instruction opcodes.
package bs_tap_controller_pkg;

  localparam int unsigned TAP_STATE_W = 4;
  localparam int unsigned IDCODE_W    = 32;

  // Opcode values below the all-ones BYPASS code; widened to the IR length at use.
  localparam int unsigned OPC_EXTEST  = 0;
  localparam int unsigned OPC_SAMPLE  = 1;
  localparam int unsigned OPC_IDCODE  = 2;

  typedef enum logic [TAP_STATE_W-1:0] {
    TAP_EX2_DR   = 4'h0,
    TAP_EX1_DR   = 4'h1,
    TAP_SH_DR    = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8,
    TAP_EX1_IR   = 4'h9,
    TAP_SH_IR    = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_BSR    = 2'd2
  } dr_sel_e;

endpackage

// File: rtl/bs_tap_controller_fsm.sv
// 16-state IEEE 1149.1 TAP state machine clocked by TCK, advanced by TMS.
module bs_tap_controller_fsm
  import bs_tap_controller_pkg::*;
(
  input  logic                   i_clock,
  input  logic                   i_rst,
  input  logic                   i_tms,
  output logic [TAP_STATE_W-1:0] o_tap_state,
  output logic [TAP_STATE_W-1:0] o_state_next_c
);

  tap_state_e r_state;
  tap_state_e w_state_next;

  always_ff @(posedge i_clock) begin
    if (i_rst) r_state <= TAP_TLR;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TAP_TLR:      w_state_next = i_tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:      w_state_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   w_state_next = i_tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   w_state_next = i_tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:    w_state_next = i_tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR:   w_state_next = i_tms ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: w_state_next = i_tms ? TAP_EX2_DR : TAP_PAUSE_DR;
      TAP_EX2_DR:   w_state_next = i_tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR:   w_state_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR:   w_state_next = i_tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR:   w_state_next = i_tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:    w_state_next = i_tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR:   w_state_next = i_tms ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: w_state_next = i_tms ? TAP_EX2_IR : TAP_PAUSE_IR;
      TAP_EX2_IR:   w_state_next = i_tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR:   w_state_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      default:      w_state_next = TAP_TLR;
    endcase
  end

  assign o_tap_state    = r_state;
  assign o_state_next_c = w_state_next;

endmodule

// File: rtl/bs_tap_controller.sv
// TAP controller top: instruction register, bypass/IDCODE data registers, BSR strobe
// decode and registered TDO mux.
module bs_tap_controller
  import bs_tap_controller_pkg::*;
#(
  parameter int unsigned         IR_LEN  = 4,
  parameter logic [IDCODE_W-1:0] ID_CODE = 32'h1000_0001
) (
  input  logic                   i_clock,
  input  logic                   i_rst,
  input  logic                   i_tms,
  input  logic                   i_tdi,
  output logic                   o_tdo,
  output logic                   o_tdo_en,
  output logic                   o_bsr_sin_c,
  input  logic                   i_bsr_sout,
  output logic                   o_shift_br,
  output logic                   o_clock_br,
  output logic                   o_update_br,
  output logic                   o_mode_control,
  output logic [TAP_STATE_W-1:0] o_tap_state
);

  localparam logic [IR_LEN-1:0] IR_EXTEST  = IR_LEN'(OPC_EXTEST);
  localparam logic [IR_LEN-1:0] IR_SAMPLE  = IR_LEN'(OPC_SAMPLE);
  localparam logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(OPC_IDCODE);
  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(1);

  logic [TAP_STATE_W-1:0] w_state_raw;
  logic [TAP_STATE_W-1:0] w_state_next_raw;
  tap_state_e             w_state;
  tap_state_e             w_state_next;

  logic [IR_LEN-1:0]   r_ir;
  logic [IR_LEN-1:0]   r_ir_sh;
  logic                r_bypass;
  logic [IDCODE_W-1:0] r_id_sh;
  logic                r_tdo;
  logic                r_tdo_en;
  logic                r_shift_br;
  logic                r_clock_br;
  logic                r_update_br;
  logic                r_mode;

  logic [IR_LEN-1:0] w_ir_next;
  dr_sel_e           w_sel;
  dr_sel_e           w_sel_next;
  logic              w_tdo_next;
  logic              w_bsr_next;

  // Anything that is not EXTEST/SAMPLE/IDCODE falls through to the bypass bit.
  function automatic dr_sel_e decode_dr(input logic [IR_LEN-1:0] ir);
    if (ir == IR_EXTEST || ir == IR_SAMPLE) return DR_BSR;
    if (ir == IR_IDCODE)                    return DR_IDCODE;
    return DR_BYPASS;
  endfunction

  bs_tap_controller_fsm u_fsm (
    .i_clock        (i_clock),
    .i_rst          (i_rst),
    .i_tms          (i_tms),
    .o_tap_state    (w_state_raw),
    .o_state_next_c (w_state_next_raw)
  );

  assign w_state      = tap_state_e'(w_state_raw);
  assign w_state_next = tap_state_e'(w_state_next_raw);

  // Next active IR and registered-output decode, evaluated against the next state so
  // the strobes line up with the state the FSM is entering.
  always_comb begin
    w_ir_next = r_ir;
    if (w_state == TAP_UPD_IR)   w_ir_next = r_ir_sh;
    if (w_state_next == TAP_TLR) w_ir_next = IR_IDCODE;
    w_sel      = decode_dr(r_ir);
    w_sel_next = decode_dr(w_ir_next);
    w_bsr_next = (w_sel_next == DR_BSR);
    w_tdo_next = 1'b0;
    if (w_state == TAP_SH_IR) begin
      w_tdo_next = r_ir_sh[0];
    end else if (w_state == TAP_SH_DR) begin
      case (w_sel)
        DR_BSR:    w_tdo_next = i_bsr_sout;
        DR_IDCODE: w_tdo_next = r_id_sh[0];
        default:   w_tdo_next = r_bypass;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_ir        <= IR_IDCODE;
      r_ir_sh     <= IR_CAPTURE;
      r_bypass    <= 1'b0;
      r_id_sh     <= ID_CODE;
      r_tdo       <= 1'b0;
      r_tdo_en    <= 1'b0;
      r_shift_br  <= 1'b0;
      r_clock_br  <= 1'b0;
      r_update_br <= 1'b0;
      r_mode      <= 1'b0;
    end else begin
      r_ir <= w_ir_next;
      case (w_state)
        TAP_CAP_IR: r_ir_sh <= IR_CAPTURE;
        TAP_SH_IR:  r_ir_sh <= {i_tdi, r_ir_sh[IR_LEN-1:1]};
        default:    r_ir_sh <= r_ir_sh;
      endcase
      case (w_state)
        TAP_CAP_DR: begin
          r_bypass <= 1'b0;
          r_id_sh  <= ID_CODE;
        end
        TAP_SH_DR: begin
          r_bypass <= i_tdi;
          r_id_sh  <= {i_tdi, r_id_sh[IDCODE_W-1:1]};
        end
        default: begin
          r_bypass <= r_bypass;
          r_id_sh  <= r_id_sh;
        end
      endcase
      r_tdo       <= w_tdo_next;
      r_tdo_en    <= (w_state == TAP_SH_IR) || (w_state == TAP_SH_DR);
      r_clock_br  <= w_bsr_next &&
                     ((w_state_next == TAP_CAP_DR) || (w_state_next == TAP_SH_DR));
      r_shift_br  <= w_bsr_next && (w_state_next == TAP_SH_DR);
      r_update_br <= w_bsr_next && (w_state_next == TAP_UPD_DR);
      r_mode      <= (w_ir_next == IR_EXTEST);
    end
  end

  assign o_tdo          = r_tdo;
  assign o_tdo_en       = r_tdo_en;
  assign o_bsr_sin_c    = i_tdi;
  assign o_shift_br     = r_shift_br;
  assign o_clock_br     = r_clock_br;
  assign o_update_br    = r_update_br;
  assign o_mode_control = r_mode;
  assign o_tap_state    = w_state_raw;

endmodule

// File: tb/tb_bs_tap_controller.sv
// Self-checking bench for bs_tap_controller against a queue-based TAP reference model.
module tb_bs_tap_controller;
  import bs_tap_controller_pkg::*;

  localparam int unsigned IR_LEN = 4;
  localparam logic [31:0] ID_CODE = 32'h1000_0001;

  logic       clk = 1'b0;
  logic       rst, tms, tdi, bsr_sout;
  logic       tdo, tdo_en, bsr_sin, shift_br, clock_br, update_br, mode;
  logic [3:0] tap_state;

  always #5 clk = ~clk;

  bs_tap_controller #(.IR_LEN(IR_LEN), .ID_CODE(ID_CODE)) dut (
    .i_clock        (clk),
    .i_rst          (rst),
    .i_tms          (tms),
    .i_tdi          (tdi),
    .o_tdo          (tdo),
    .o_tdo_en       (tdo_en),
    .o_bsr_sin_c    (bsr_sin),
    .i_bsr_sout     (bsr_sout),
    .o_shift_br     (shift_br),
    .o_clock_br     (clock_br),
    .o_update_br    (update_br),
    .o_mode_control (mode),
    .o_tap_state    (tap_state)
  );

  int n_cmp, n_fail;

  // Reference model: transition table plus FIFO views of the IR and selected DR.
  tap_state_e nxt0 [16];
  tap_state_e nxt1 [16];
  tap_state_e m_state;
  logic [3:0] m_ir;
  logic       m_irq [$];
  logic       m_drq [$];
  logic       m_tdo, m_tdo_en;
  logic [31:0] idc;

  logic obs_tdo_q [$];
  logic exp_tdo_q [$];
  int   obs_cbr, exp_cbr, obs_sbr, exp_sbr, obs_ubr, exp_ubr, obs_quiet;

  function automatic logic is_bsr(input logic [3:0] ir);
    return (ir == 4'd0) || (ir == 4'd1);
  endfunction

  function automatic logic is_quiet(input tap_state_e s);
    return (s == TAP_EX1_DR) || (s == TAP_PAUSE_DR) || (s == TAP_EX2_DR) ||
           (s == TAP_EX1_IR) || (s == TAP_PAUSE_IR) || (s == TAP_EX2_IR);
  endfunction

  task automatic arc(input tap_state_e s, input tap_state_e n0, input tap_state_e n1);
    nxt0[s] = n0;
    nxt1[s] = n1;
  endtask

  task automatic clear_trace();
    obs_tdo_q.delete(); exp_tdo_q.delete();
    obs_cbr = 0; exp_cbr = 0; obs_sbr = 0; exp_sbr = 0;
    obs_ubr = 0; exp_ubr = 0; obs_quiet = 0;
  endtask

  // One TCK cycle: drive, advance the model on the edge, then sample the DUT 1ns later.
  task automatic tick(input logic t_tms, input logic t_tdi, input logic t_rst);
    logic sout;
    tap_state_e s;
    sout = 1'($urandom);
    tms = t_tms; tdi = t_tdi; rst = t_rst; bsr_sout = sout;
    @(posedge clk);
    s = m_state;
    if (t_rst) begin
      m_state = TAP_TLR; m_ir = 4'b0010; m_tdo = 1'b0; m_tdo_en = 1'b0;
      m_irq.delete(); m_drq.delete();
    end else begin
      m_tdo_en = (s == TAP_SH_IR) || (s == TAP_SH_DR);
      m_tdo = 1'b0;
      case (s)
        TAP_CAP_IR: begin
          m_irq.delete(); m_irq.push_back(1'b1);
          for (int i = 1; i < IR_LEN; i++) m_irq.push_back(1'b0);
        end
        TAP_SH_IR: begin m_tdo = m_irq.pop_front(); m_irq.push_back(t_tdi); end
        TAP_UPD_IR: for (int i = 0; i < IR_LEN; i++) m_ir[i] = m_irq[i];
        TAP_CAP_DR: begin
          m_drq.delete();
          if (m_ir == 4'd2) for (int i = 0; i < 32; i++) m_drq.push_back(idc[i]);
          else if (!is_bsr(m_ir)) m_drq.push_back(1'b0);
        end
        TAP_SH_DR: begin
          if (is_bsr(m_ir)) m_tdo = sout;
          else begin m_tdo = m_drq.pop_front(); m_drq.push_back(t_tdi); end
        end
        default: ;
      endcase
      m_state = t_tms ? nxt1[s] : nxt0[s];
      if (m_state == TAP_TLR) m_ir = 4'b0010;
    end
    #1;
    if (tdo_en) obs_tdo_q.push_back(tdo);
    if (m_tdo_en) exp_tdo_q.push_back(m_tdo);
    if (clock_br)  obs_cbr++;
    if (shift_br)  obs_sbr++;
    if (update_br) obs_ubr++;
    if (is_bsr(m_ir) && (m_state == TAP_CAP_DR || m_state == TAP_SH_DR)) exp_cbr++;
    if (is_bsr(m_ir) && m_state == TAP_SH_DR)  exp_sbr++;
    if (is_bsr(m_ir) && m_state == TAP_UPD_DR) exp_ubr++;
    if ((clock_br || shift_br || update_br) && is_quiet(m_state)) obs_quiet++;
  endtask

  // Load an opcode from RTI; ends back in RTI. Reports MODE seen while in UpdIR.
  task automatic scan_ir(input logic [3:0] op, output logic mode_at_upd);
    tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < IR_LEN; i++) tick(i == IR_LEN - 1, op[i], 0);
    tick(1, 0, 0);
    mode_at_upd = mode;
    tick(0, 0, 0);
  endtask

  // DR scan of n shifts from RTI, optionally detouring through PauseDR after pause_at shifts.
  task automatic scan_dr(input int n, input logic [63:0] bits, input int pause_at);
    logic last, brk;
    tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      brk  = (i == pause_at - 1) && !last;
      tick(last || brk, bits[i], 0);
      if (brk) begin tick(0, 0, 0); tick(0, 0, 0); tick(1, 0, 0); tick(0, 0, 0); end
    end
    tick(1, 0, 0); tick(0, 0, 0);
  endtask

  task automatic test_reset();
    tick(1, 0, 1);
    n_cmp++; if (tap_state !== TAP_TLR) begin n_fail++; $display("FAIL reset_state: got %h want %h", tap_state, TAP_TLR); end
    n_cmp++; if (mode !== 1'b0) begin n_fail++; $display("FAIL reset_mode: got %b want 0", mode); end
    n_cmp++; if (tdo_en !== 1'b0) begin n_fail++; $display("FAIL reset_tdo_en: got %b want 0", tdo_en); end
    n_cmp++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL reset_tdo: got %b want 0", tdo); end
    n_cmp++; if ({clock_br, shift_br, update_br} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {clock_br, shift_br, update_br}); end
    tick(1, 0, 0);
    n_cmp++; if (tap_state !== TAP_TLR) begin n_fail++; $display("FAIL tlr_hold: got %h want %h", tap_state, TAP_TLR); end
    tick(0, 1, 0);
    n_cmp++; if (tap_state !== TAP_RTI) begin n_fail++; $display("FAIL tlr_to_rti: got %h want %h", tap_state, TAP_RTI); end
    n_cmp++; if (bsr_sin !== tdi) begin n_fail++; $display("FAIL bsr_sin: got %b want %b", bsr_sin, tdi); end
  endtask

  task automatic test_tlr_from_shdr();
    tick(0, 0, 1); tick(0, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    n_cmp++; if (tap_state !== TAP_SH_DR) begin n_fail++; $display("FAIL reach_shdr: got %h want %h", tap_state, TAP_SH_DR); end
    for (int k = 1; k <= 5; k++) begin
      tick(1, 0, 0);
      n_cmp++; if (tap_state !== m_state) begin n_fail++; $display("FAIL shdr_tms1_%0d: got %h want %h", k, tap_state, m_state); end
    end
    n_cmp++; if (tap_state !== TAP_TLR) begin n_fail++; $display("FAIL shdr_to_tlr: got %h want %h", tap_state, TAP_TLR); end
  endtask

  task automatic test_tlr_sweep();
    bit seen [16];
    int covered, len;
    foreach (seen[i]) seen[i] = 1'b0;
    tick(0, 0, 1);
    clear_trace();
    for (int it = 0; it < 1000; it++) begin
      covered = 0;
      foreach (seen[i]) covered += int'(seen[i]);
      if (covered == 16) break;
      len = $urandom_range(0, 10);
      for (int k = 0; k < len; k++) begin
        tick(1'($urandom), 1'($urandom), 0);
        n_cmp++; if (tap_state !== m_state) begin n_fail++; $display("FAIL walk_state: got %h want %h", tap_state, m_state); end
      end
      seen[m_state] = 1'b1;
      for (int k = 0; k < 5; k++) tick(1, 1'($urandom), 0);
      n_cmp++; if (tap_state !== TAP_TLR) begin n_fail++; $display("FAIL sweep_to_tlr: got %h want %h", tap_state, TAP_TLR); end
    end
    covered = 0;
    foreach (seen[i]) covered += int'(seen[i]);
    n_cmp++; if (covered != 16) begin n_fail++; $display("FAIL sweep_cover: got %0d want 16", covered); end
    n_cmp++; if (obs_tdo_q.size() != exp_tdo_q.size()) begin n_fail++; $display("FAIL sweep_tdo_len: got %0d want %0d", obs_tdo_q.size(), exp_tdo_q.size()); end
    for (int i = 0; i < obs_tdo_q.size() && i < exp_tdo_q.size(); i++) begin
      n_cmp++; if (obs_tdo_q[i] !== exp_tdo_q[i]) begin n_fail++; $display("FAIL sweep_tdo[%0d]: got %b want %b", i, obs_tdo_q[i], exp_tdo_q[i]); end
    end
    n_cmp++; if ({obs_cbr, obs_sbr, obs_ubr} != {exp_cbr, exp_sbr, exp_ubr}) begin n_fail++; $display("FAIL sweep_strobes: got %0d/%0d/%0d want %0d/%0d/%0d", obs_cbr, obs_sbr, obs_ubr, exp_cbr, exp_sbr, exp_ubr); end
  endtask

  task automatic test_ir_extest();
    logic       m_upd;
    logic [3:0] capv;
    capv = 4'b0001;
    tick(0, 0, 1); tick(0, 0, 0);
    clear_trace();
    scan_ir(4'b0000, m_upd);
    n_cmp++; if (obs_tdo_q.size() != 4) begin n_fail++; $display("FAIL ir_tdo_len: got %0d want 4", obs_tdo_q.size()); end
    for (int i = 0; i < 4 && i < obs_tdo_q.size(); i++) begin
      n_cmp++; if (obs_tdo_q[i] !== capv[i]) begin n_fail++; $display("FAIL ir_capture[%0d]: got %b want %b", i, obs_tdo_q[i], capv[i]); end
    end
    n_cmp++; if (m_upd !== 1'b0) begin n_fail++; $display("FAIL mode_in_updir: got %b want 0", m_upd); end
    n_cmp++; if (mode !== 1'b1) begin n_fail++; $display("FAIL mode_after_updir: got %b want 1", mode); end
  endtask

  task automatic test_bypass();
    logic       m_upd;
    logic [7:0] pat;
    pat = 8'b10110010;
    tick(0, 0, 1); tick(0, 0, 0);
    scan_ir(4'b1111, m_upd);
    clear_trace();
    scan_dr(8, 64'(pat), 0);
    n_cmp++; if (obs_tdo_q.size() != 8) begin n_fail++; $display("FAIL bypass_len: got %0d want 8", obs_tdo_q.size()); end
    for (int k = 0; k < 8 && k < obs_tdo_q.size(); k++) begin
      n_cmp++;
      if (obs_tdo_q[k] !== ((k == 0) ? 1'b0 : pat[k-1])) begin
        n_fail++; $display("FAIL bypass_tdo[%0d]: got %b want %b", k, obs_tdo_q[k], (k == 0) ? 1'b0 : pat[k-1]);
      end
    end
    n_cmp++; if (obs_cbr + obs_sbr + obs_ubr != 0) begin n_fail++; $display("FAIL bypass_strobes: got %0d/%0d/%0d want 0/0/0", obs_cbr, obs_sbr, obs_ubr); end
    n_cmp++; if (mode !== 1'b0) begin n_fail++; $display("FAIL bypass_mode: got %b want 0", mode); end
  endtask

  task automatic test_extest_dr();
    logic m_upd;
    tick(0, 0, 1); tick(0, 0, 0);
    scan_ir(4'b0000, m_upd);
    clear_trace();
    scan_dr(6, {$urandom, $urandom}, 3);
    n_cmp++; if (obs_cbr != 7) begin n_fail++; $display("FAIL extest_clockbr: got %0d want 7", obs_cbr); end
    n_cmp++; if (obs_sbr != 6) begin n_fail++; $display("FAIL extest_shiftbr: got %0d want 6", obs_sbr); end
    n_cmp++; if (obs_ubr != 1) begin n_fail++; $display("FAIL extest_updatebr: got %0d want 1", obs_ubr); end
    n_cmp++; if (obs_quiet != 0) begin n_fail++; $display("FAIL extest_pause_strobe: got %0d want 0", obs_quiet); end
    n_cmp++; if (mode !== 1'b1) begin n_fail++; $display("FAIL extest_mode: got %b want 1", mode); end
    n_cmp++; if (obs_tdo_q.size() != 6) begin n_fail++; $display("FAIL extest_tdo_len: got %0d want 6", obs_tdo_q.size()); end
    for (int i = 0; i < obs_tdo_q.size() && i < exp_tdo_q.size(); i++) begin
      n_cmp++; if (obs_tdo_q[i] !== exp_tdo_q[i]) begin n_fail++; $display("FAIL extest_tdo[%0d]: got %b want %b", i, obs_tdo_q[i], exp_tdo_q[i]); end
    end
  endtask

  task automatic test_idcode();
    logic       m_upd;
    logic [3:0] capv;
    capv = 4'b0001;
    tick(0, 0, 1); tick(0, 0, 0);
    clear_trace();
    scan_dr(32, {$urandom, $urandom}, 0);
    n_cmp++; if (obs_tdo_q.size() != 32) begin n_fail++; $display("FAIL idcode_len: got %0d want 32", obs_tdo_q.size()); end
    for (int i = 0; i < 32 && i < obs_tdo_q.size(); i++) begin
      n_cmp++; if (obs_tdo_q[i] !== idc[i]) begin n_fail++; $display("FAIL idcode_bit[%0d]: got %b want %b", i, obs_tdo_q[i], idc[i]); end
    end
    n_cmp++; if (obs_tdo_q.size() > 0 && obs_tdo_q[0] !== 1'b1) begin n_fail++; $display("FAIL idcode_bit0: got %b want 1", obs_tdo_q[0]); end
    tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < 10; i++) tick(0, 1'($urandom), 0);
    tick(0, 1, 1);
    n_cmp++; if (tap_state !== TAP_TLR) begin n_fail++; $display("FAIL midshift_reset_state: got %h want %h", tap_state, TAP_TLR); end
    n_cmp++; if (tdo_en !== 1'b0) begin n_fail++; $display("FAIL midshift_reset_tdo_en: got %b want 0", tdo_en); end
    tick(0, 0, 0);
    clear_trace();
    scan_dr(8, 64'(0), 0);
    for (int i = 0; i < 8 && i < obs_tdo_q.size(); i++) begin
      n_cmp++; if (obs_tdo_q[i] !== idc[i]) begin n_fail++; $display("FAIL post_reset_idcode[%0d]: got %b want %b", i, obs_tdo_q[i], idc[i]); end
    end
    clear_trace();
    scan_ir(4'b1111, m_upd);
    n_cmp++; if (obs_tdo_q.size() != 4) begin n_fail++; $display("FAIL post_reset_ir_len: got %0d want 4", obs_tdo_q.size()); end
    for (int i = 0; i < 4 && i < obs_tdo_q.size(); i++) begin
      n_cmp++; if (obs_tdo_q[i] !== capv[i]) begin n_fail++; $display("FAIL post_reset_ir[%0d]: got %b want %b", i, obs_tdo_q[i], capv[i]); end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic       m_upd;
    int         n;
    tick(0, 0, 1); tick(0, 0, 0);
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 4))
        0: op = 4'd0;
        1: op = 4'd1;
        2: op = 4'd2;
        3: op = 4'hF;
        default: op = 4'($urandom);
      endcase
      scan_ir(op, m_upd);
      n_cmp++; if (mode !== (m_ir == 4'd0)) begin n_fail++; $display("FAIL rand_mode op=%h: got %b want %b", op, mode, m_ir == 4'd0); end
      clear_trace();
      n = $urandom_range(1, 40);
      scan_dr(n, {$urandom, $urandom}, $urandom_range(0, n));
      n_cmp++; if (obs_tdo_q.size() != exp_tdo_q.size()) begin n_fail++; $display("FAIL rand_tdo_len op=%h: got %0d want %0d", op, obs_tdo_q.size(), exp_tdo_q.size()); end
      for (int i = 0; i < obs_tdo_q.size() && i < exp_tdo_q.size(); i++) begin
        n_cmp++; if (obs_tdo_q[i] !== exp_tdo_q[i]) begin n_fail++; $display("FAIL rand_tdo[%0d] op=%h: got %b want %b", i, op, obs_tdo_q[i], exp_tdo_q[i]); end
      end
      n_cmp++; if ({obs_cbr, obs_sbr, obs_ubr} != {exp_cbr, exp_sbr, exp_ubr}) begin n_fail++; $display("FAIL rand_strobes op=%h: got %0d/%0d/%0d want %0d/%0d/%0d", op, obs_cbr, obs_sbr, obs_ubr, exp_cbr, exp_sbr, exp_ubr); end
      n_cmp++; if (obs_quiet != 0) begin n_fail++; $display("FAIL rand_pause_strobe op=%h: got %0d want 0", op, obs_quiet); end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; tms = 1'b0; tdi = 1'b0; bsr_sout = 1'b0;
    idc = ID_CODE;
    m_state = TAP_TLR; m_ir = 4'b0010; m_tdo = 1'b0; m_tdo_en = 1'b0;
    arc(TAP_TLR,      TAP_RTI,      TAP_TLR);
    arc(TAP_RTI,      TAP_RTI,      TAP_SEL_DR);
    arc(TAP_SEL_DR,   TAP_CAP_DR,   TAP_SEL_IR);
    arc(TAP_CAP_DR,   TAP_SH_DR,    TAP_EX1_DR);
    arc(TAP_SH_DR,    TAP_SH_DR,    TAP_EX1_DR);
    arc(TAP_EX1_DR,   TAP_PAUSE_DR, TAP_UPD_DR);
    arc(TAP_PAUSE_DR, TAP_PAUSE_DR, TAP_EX2_DR);
    arc(TAP_EX2_DR,   TAP_SH_DR,    TAP_UPD_DR);
    arc(TAP_UPD_DR,   TAP_RTI,      TAP_SEL_DR);
    arc(TAP_SEL_IR,   TAP_CAP_IR,   TAP_TLR);
    arc(TAP_CAP_IR,   TAP_SH_IR,    TAP_EX1_IR);
    arc(TAP_SH_IR,    TAP_SH_IR,    TAP_EX1_IR);
    arc(TAP_EX1_IR,   TAP_PAUSE_IR, TAP_UPD_IR);
    arc(TAP_PAUSE_IR, TAP_PAUSE_IR, TAP_EX2_IR);
    arc(TAP_EX2_IR,   TAP_SH_IR,    TAP_UPD_IR);
    arc(TAP_UPD_IR,   TAP_RTI,      TAP_SEL_DR);
    clear_trace();
    test_reset();
    test_tlr_from_shdr();
    test_tlr_sweep();
    test_ir_extest();
    test_bypass();
    test_extest_dr();
    test_idcode();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
